// File: rtl/imem_boot_pkg.sv
// rtl/imem_boot_pkg.sv - shared types and constants for the instruction memory boot loader
package imem_boot_pkg;

  // DONE with error set is the ERROR state; it needs no separate encoding.
  typedef enum logic [2:0] {
    LEN0 = 3'd0,
    LEN1 = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_LEN_WIDTH  = 16;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs a byte stream little-endian into 32-bit words
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   clear      in   synchronous restart of the byte index
//   accept     in   a byte is consumed this cycle
//   byte_data  in   the consumed byte
//   word_valid out  this accept completes a word (combinational)
//   word       out  the completed word, valid with word_valid
module imem_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx;
  // Only the lower lanes are stored; the top lane comes straight from the
  // incoming byte so the word is complete on the accepting edge.
  logic [8*(BYTES_PER_WORD-1)-1:0] lanes;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      lanes <= '0;
    end else if (clear) begin
      idx   <= '0;
      lanes <= '0;
    end else if (accept) begin
      for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
        if (idx == IDX_W'(i)) lanes[8*i +: 8] <= byte_data;
      end
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  assign word_valid = accept && (idx == LAST_IDX);
  assign word       = {byte_data, lanes};

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - fills instruction memory from a length-prefixed byte stream at boot
//
// Optional trailing XOR checksum byte: define IMEM_BOOT_CHECKSUM_EN.
//
// Ports:
//   clock, reset        clock (rising edge), asynchronous active-low reset
//   in_data/in_valid    stream byte and its valid
//   in_ready            block can accept a byte
//   mem_we/mem_addr/mem_wdata  one-cycle word write to instruction memory
//   cpu_reset           active-high processor reset, held while loading
//   done                image loaded and accepted
//   error               sticky load error (overflow or checksum mismatch)
//   words_loaded        words counted so far
//   reload              pulse in DONE/ERROR to restart loading
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [LEN_WIDTH-1:0]  words_loaded,
  input  logic                  reload
);

  localparam logic [LEN_WIDTH-1:0] DEPTH = LEN_WIDTH'(2 ** ADDR_WIDTH);

  state_t               state;
  logic [LEN_WIDTH-1:0] count;
  logic                 accept;
  logic                 word_valid;
  logic [31:0]          word;
  logic [LEN_WIDTH-1:0] hdr_count;
  logic                 last_word;
  logic                 in_range;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]           acc;
  logic                 chk_error;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_count = LEN_WIDTH'({in_data, count[7:0]});
  assign last_word = (words_loaded + LEN_WIDTH'(1)) == count;
  // Words past the end of memory are counted but never written.
  assign in_range  = words_loaded < DEPTH;
`ifdef IMEM_BOOT_CHECKSUM_EN
  assign chk_error = error || (in_data != acc);
`endif

  imem_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      ((state == DONE) && reload),
    .accept     (accept && (state == DATA)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= LEN0;
      in_ready     <= 1'b0;
      count        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      acc          <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN0: begin
          in_ready <= 1'b1;
          if (accept) begin
            count[7:0] <= in_data;
            state      <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            count <= hdr_count;
            if (hdr_count > DEPTH) error <= 1'b1;
            if (hdr_count == '0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
              state <= CHK;
`else
              state     <= DONE;
              in_ready  <= 1'b0;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            acc <= acc ^ in_data;
`endif
            if (word_valid) begin
              mem_we       <= in_range;
              mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
              mem_wdata    <= word;
              words_loaded <= words_loaded + LEN_WIDTH'(1);
              if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                state <= CHK;
`else
                state     <= DONE;
                in_ready  <= 1'b0;
                done      <= !error;
                cpu_reset <= error;
`endif
              end
            end
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            error     <= chk_error;
            done      <= !chk_error;
            cpu_reset <= chk_error;
          end
        end
`endif
        DONE: begin
          if (reload) begin
            state        <= LEN0;
            in_ready     <= 1'b1;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            acc          <= '0;
`endif
          end
        end
        default: begin
          state <= LEN0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          reload = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] img[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always #5 clock = ~clock;

  imem_boot_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clock        (clock),
    .reset        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .reload       (reload)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory write log and the processor-reset invariant, sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (rst_n) chk("cpu_reset_vs_done", {31'b0, cpu_reset}, {31'b0, !done});
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        vectors++;
        miscompares++;
        $error("FAIL send_timeout: in_ready observed 0 for 200 cycles, expected 1");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reload();
    @(negedge clock);
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
    chk("reload_done", {31'b0, done}, 32'd0);
    chk("reload_error", {31'b0, error}, 32'd0);
    chk("reload_words", {16'b0, words_loaded}, 32'd0);
    chk("reload_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("reload_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  // Reference: word k of img lands at address k for k < DEPTH; bytes go
  // out little-endian after a little-endian 16-bit word count.
  task automatic load_image(input int count, input int gap_max, input logic [7:0] chk_bias);
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] cnt;
    bit ovf;
    bit exp_err;
    int nwr;
    x   = 8'h00;
    cnt = 16'(count);
    ovf = count > DEPTH;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(cnt[7:0]);
    if (gap_max > 0) idle($urandom_range(1, gap_max));
    send_byte(cnt[15:8]);
    chk("hdr_error", {31'b0, error}, {31'b0, ovf});
    for (int k = 0; k < count; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = img[k][8*j +: 8];
        if (gap_max > 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, gap_max));
        send_byte(b);
        x ^= b;
        chk("we_latency", {31'b0, mem_we}, {31'b0, (j == 3) && (k < DEPTH)});
        if (j == 3 && k < DEPTH) begin
          chk("addr_at_pulse", {26'b0, mem_addr}, 32'(k));
          chk("wdata_at_pulse", mem_wdata, img[k]);
        end
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(x ^ chk_bias);
    exp_err = ovf || (chk_bias != 8'h00);
`else
    exp_err = ovf;
    x       = chk_bias;
`endif
    idle(2);
    nwr = (count < DEPTH) ? count : DEPTH;
    chk("write_count", 32'(wr_addr_q.size()), 32'(nwr));
    for (int k = 0; k < nwr && k < wr_addr_q.size(); k++) begin
      chk("log_addr", 32'(wr_addr_q[k]), 32'(k));
      chk("log_data", wr_data_q[k], img[k]);
    end
    chk("final_done", {31'b0, done}, {31'b0, !exp_err});
    chk("final_error", {31'b0, error}, {31'b0, exp_err});
    chk("final_cpu_reset", {31'b0, cpu_reset}, {31'b0, exp_err});
    chk("final_words", {16'b0, words_loaded}, 32'(count));
    chk("final_in_ready", {31'b0, in_ready}, 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {26'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_words", {16'b0, words_loaded}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", {31'b0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    chk("in_ready_after_edge", {31'b0, in_ready}, 32'd1);

    // Empty image right after reset release.
    img.delete();
    load_image(0, 0, 8'h00);
    do_reload();

    // Directed two-word image.
    img.delete();
    img.push_back(32'h1400_0006);
    img.push_back(32'h8B12_0202);
    load_image(2, 0, 8'h00);
    do_reload();

    // Random three-word image, gap-free then with gaps; reload in LEN0 is ignored.
    img.delete();
    repeat (3) img.push_back($urandom);
    load_image(3, 0, 8'h00);
    do_reload();
    @(negedge clock);
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
    chk("reload_ignored_ready", {31'b0, in_ready}, 32'd1);
    load_image(3, 4, 8'h00);

    // Overflow: 65 words into 64-word memory.
    do_reload();
    img.delete();
    repeat (DEPTH + 1) img.push_back($urandom);
    load_image(DEPTH + 1, 0, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("error_hold_words", {16'b0, words_loaded}, 32'(DEPTH + 1));
    chk("error_hold_ready", {31'b0, in_ready}, 32'd0);
    chk("error_hold_writes", 32'(wr_addr_q.size()), 32'(DEPTH));
    do_reload();

    // Asynchronous reset after 5 of 8 data bytes.
    img.delete();
    repeat (2) img.push_back($urandom);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(img[i / 4][8*(i % 4) +: 8]);
    chk("partial_words", {16'b0, words_loaded}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", {31'b0, in_ready}, 32'd0);
    chk("async_mem_we", {31'b0, mem_we}, 32'd0);
    chk("async_mem_addr", {26'b0, mem_addr}, 32'd0);
    chk("async_mem_wdata", mem_wdata, 32'd0);
    chk("async_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("async_done", {31'b0, done}, 32'd0);
    chk("async_error", {31'b0, error}, 32'd0);
    chk("async_words", {16'b0, words_loaded}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    load_image(2, 2, 8'h00);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum match and mismatch on the 0x01,0x02,0x04,0x08 word.
    do_reload();
    img.delete();
    img.push_back(32'h0804_0201);
    load_image(1, 0, 8'h00);
    do_reload();
    load_image(1, 0, 8'h01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
